// File: rtl/decode_if.sv
// decode_if: decode-stage bus (D pipe register in, forwarding/write-back in, E pipe register out)
interface decode_if;
  logic [3:0]  D_icode, D_ifun, D_rA, D_rB, D_stat;
  logic [63:0] D_valC, D_valP;
  logic        E_bubble;
  logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
  logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
  logic [3:0]  d_srcA, d_srcB;
  logic [3:0]  E_icode, E_ifun, E_stat, E_dstE, E_dstM, E_srcA, E_srcB;
  logic [63:0] E_valC, E_valA, E_valB;
  modport master (
    output D_icode, D_ifun, D_rA, D_rB, D_stat, D_valC, D_valP, E_bubble,
           e_dstE, e_valE, M_dstE, M_valE, M_dstM, m_valM, W_dstE, W_valE, W_dstM, W_valM,
    input  d_srcA, d_srcB, E_icode, E_ifun, E_stat, E_valC, E_valA, E_valB,
           E_dstE, E_dstM, E_srcA, E_srcB
  );
  modport slave (
    input  D_icode, D_ifun, D_rA, D_rB, D_stat, D_valC, D_valP, E_bubble,
           e_dstE, e_valE, M_dstE, M_valE, M_dstM, m_valM, W_dstE, W_valE, W_dstM, W_valM,
    output d_srcA, d_srcB, E_icode, E_ifun, E_stat, E_valC, E_valA, E_valB,
           E_dstE, E_dstM, E_srcA, E_srcB
  );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: Y86-64 decode/write-back with register file, E/M/W forwarding and E pipe register
module decode_stage #(
  parameter logic [3:0] RSP   = 4'h4,
  parameter logic [3:0] RNONE = 4'hF
) (
  input logic     clk,
  input logic     rst,
  decode_if.slave bus
);
  typedef struct packed {
    logic [3:0]  icode, ifun, stat;
    logic [63:0] valc, vala, valb;
    logic [3:0]  dste, dstm, srca, srcb;
  } e_t;
  localparam e_t BUBBLE = '{icode: 4'h1, ifun: 4'h0, stat: 4'h8, valc: 64'h0, vala: 64'h0,
                            valb: 64'h0, dste: RNONE, dstm: RNONE, srca: RNONE, srcb: RNONE};
  logic [63:0] rf_q [15];
  logic [63:0] rf_d [15];
  e_t          e_q, e_d;
  logic [3:0]  src_a, src_b, dst_e, dst_m;
  logic [63:0] val_a, val_b;
  logic [3:0]  ic;
  assign ic = bus.D_icode;
  // RNONE sources are caught first, so an RNONE forwarding dst can never match
  always_comb begin
    src_a = (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) ? bus.D_rA : (ic inside {4'h9, 4'hB}) ? RSP : RNONE;
    src_b = (ic inside {4'h4, 4'h5, 4'h6}) ? bus.D_rB : (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) ? RSP : RNONE;
    dst_e = (ic inside {4'h2, 4'h3, 4'h6}) ? bus.D_rB : (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) ? RSP : RNONE;
    dst_m = (ic inside {4'h5, 4'hB}) ? bus.D_rA : RNONE;
    val_a = (ic == 4'h7 || ic == 4'h8) ? bus.D_valP :
            src_a == RNONE       ? 64'h0 :
            src_a == bus.e_dstE  ? bus.e_valE :
            src_a == bus.M_dstM  ? bus.m_valM :
            src_a == bus.M_dstE  ? bus.M_valE :
            src_a == bus.W_dstM  ? bus.W_valM :
            src_a == bus.W_dstE  ? bus.W_valE : rf_q[src_a];
    val_b = src_b == RNONE       ? 64'h0 :
            src_b == bus.e_dstE  ? bus.e_valE :
            src_b == bus.M_dstM  ? bus.m_valM :
            src_b == bus.M_dstE  ? bus.M_valE :
            src_b == bus.W_dstM  ? bus.W_valM :
            src_b == bus.W_dstE  ? bus.W_valE : rf_q[src_b];
    e_d = bus.E_bubble ? BUBBLE : '{icode: ic, ifun: bus.D_ifun, stat: bus.D_stat, valc: bus.D_valC,
                                     vala: val_a, valb: val_b, dste: dst_e, dstm: dst_m,
                                     srca: src_a, srcb: src_b};
    rf_d = rf_q;
    if (bus.W_dstE != RNONE) rf_d[bus.W_dstE] = bus.W_valE;
    if (bus.W_dstM != RNONE) rf_d[bus.W_dstM] = bus.W_valM;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      e_q  <= BUBBLE;
      rf_q <= '{default: 64'h0};
    end else begin
      e_q  <= e_d;
      rf_q <= rf_d;
    end
  end
  assign bus.d_srcA  = src_a;
  assign bus.d_srcB  = src_b;
  assign bus.E_icode = e_q.icode;
  assign bus.E_ifun  = e_q.ifun;
  assign bus.E_stat  = e_q.stat;
  assign bus.E_valC  = e_q.valc;
  assign bus.E_valA  = e_q.vala;
  assign bus.E_valB  = e_q.valb;
  assign bus.E_dstE  = e_q.dste;
  assign bus.E_dstM  = e_q.dstm;
  assign bus.E_srcA  = e_q.srca;
  assign bus.E_srcB  = e_q.srcb;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed tests for decode_stage against an instruction-level reference model
module tb_decode_stage;
  localparam logic [3:0] F = 4'hF;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  decode_if dif();
  decode_stage dut (.clk(clk), .rst(rst), .bus(dif));

  int errs = 0, total = 0;
  logic [63:0] mrf [15];
  logic        mvalid = 0;
  logic [3:0]  x_icode, x_ifun, x_stat, x_dste, x_dstm, x_srca, x_srcb;
  logic [63:0] x_valc, x_vala, x_valb;

  function automatic logic [3:0] m_srca(input logic [3:0] i, input logic [3:0] ra);
    if (i == 2 || i == 4 || i == 6 || i == 10) return ra;
    if (i == 9 || i == 11) return 4'h4;
    return F;
  endfunction
  function automatic logic [3:0] m_srcb(input logic [3:0] i, input logic [3:0] rb);
    if (i == 4 || i == 5 || i == 6) return rb;
    if (i >= 8 && i <= 11) return 4'h4;
    return F;
  endfunction
  function automatic logic [3:0] m_dste(input logic [3:0] i, input logic [3:0] rb);
    if (i == 2 || i == 3 || i == 6) return rb;
    if (i >= 8 && i <= 11) return 4'h4;
    return F;
  endfunction
  function automatic logic [3:0] m_dstm(input logic [3:0] i, input logic [3:0] ra);
    return (i == 5 || i == 11) ? ra : F;
  endfunction
  function automatic logic [63:0] m_read(input logic [3:0] s);
    logic [3:0]  ids  [5];
    logic [63:0] vals [5];
    ids  = '{dif.e_dstE, dif.M_dstM, dif.M_dstE, dif.W_dstM, dif.W_dstE};
    vals = '{dif.e_valE, dif.m_valM, dif.M_valE, dif.W_valM, dif.W_valE};
    if (s == F) return 0;
    for (int k = 0; k < 5; k++) if (ids[k] == s) return vals[k];
    return mrf[s];
  endfunction

  always @(posedge clk) begin
    if (rst || dif.E_bubble) begin
      {x_icode, x_ifun, x_stat} = {4'h1, 4'h0, 4'h8};
      {x_valc, x_vala, x_valb} = '0;
      {x_dste, x_dstm, x_srca, x_srcb} = {F, F, F, F};
    end else begin
      x_icode = dif.D_icode; x_ifun = dif.D_ifun; x_stat = dif.D_stat; x_valc = dif.D_valC;
      x_srca = m_srca(dif.D_icode, dif.D_rA); x_srcb = m_srcb(dif.D_icode, dif.D_rB);
      x_dste = m_dste(dif.D_icode, dif.D_rB); x_dstm = m_dstm(dif.D_icode, dif.D_rA);
      x_vala = (dif.D_icode == 7 || dif.D_icode == 8) ? dif.D_valP : m_read(x_srca);
      x_valb = m_read(x_srcb);
    end
    if (rst) for (int k = 0; k < 15; k++) mrf[k] = 0;
    else begin
      if (dif.W_dstE != F) mrf[dif.W_dstE] = dif.W_valE;
      if (dif.W_dstM != F) mrf[dif.W_dstM] = dif.W_valM;
    end
    if (rst) mvalid = 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) if (mvalid) begin
    chk("m_icode", dif.E_icode, x_icode); chk("m_ifun", dif.E_ifun, x_ifun);
    chk("m_stat", dif.E_stat, x_stat);    chk("m_valC", dif.E_valC, x_valc);
    chk("m_valA", dif.E_valA, x_vala);    chk("m_valB", dif.E_valB, x_valb);
    chk("m_dstE", dif.E_dstE, x_dste);    chk("m_dstM", dif.E_dstM, x_dstm);
    chk("m_srcA", dif.E_srcA, x_srca);    chk("m_srcB", dif.E_srcB, x_srcb);
    chk("m_d_srcA", dif.d_srcA, m_srca(dif.D_icode, dif.D_rA));
    chk("m_d_srcB", dif.d_srcB, m_srcb(dif.D_icode, dif.D_rB));
  end

  task automatic tick; @(posedge clk); #1; endtask
  task automatic idle;
    dif.D_icode = 1; dif.D_ifun = 0; dif.D_rA = F; dif.D_rB = F; dif.D_stat = 8;
    dif.D_valC = 0; dif.D_valP = 0; dif.E_bubble = 0;
    dif.e_dstE = F; dif.M_dstE = F; dif.M_dstM = F; dif.W_dstE = F; dif.W_dstM = F;
    dif.e_valE = 0; dif.M_valE = 0; dif.m_valM = 0; dif.W_valE = 0; dif.W_valM = 0;
  endtask
  task automatic opq(input logic [3:0] ra, input logic [3:0] rb);
    dif.D_icode = 6; dif.D_ifun = 0; dif.D_rA = ra; dif.D_rB = rb;
  endtask

  initial begin
    idle(); rst = 1;
    tick(); tick(); rst = 0;
    chk("rst_icode", dif.E_icode, 4'h1); chk("rst_stat", dif.E_stat, 4'h8);
    chk("rst_dstE", dif.E_dstE, F);      chk("rst_srcB", dif.E_srcB, F);
    for (int r = 0; r < 15; r++) begin
      opq(r[3:0], r[3:0]); tick();
      chk("rst_rf", dif.E_valA | dif.E_valB, 64'h0);
    end
    idle(); dif.W_dstE = 3; dif.W_valE = 64'h55; tick();
    idle(); opq(3, 3); tick();
    chk("wr_valA", dif.E_valA, 64'h55); chk("wr_valB", dif.E_valB, 64'h55); chk("wr_dstE", dif.E_dstE, 4'h3);
    idle(); opq(2, 7);
    dif.e_dstE = 2; dif.e_valE = 64'h11; dif.M_dstE = 2; dif.M_valE = 64'h22; dif.W_dstE = 2; dif.W_valE = 64'h33;
    tick(); chk("fwd_e", dif.E_valA, 64'h11);
    dif.e_dstE = F; tick(); chk("fwd_m", dif.E_valA, 64'h22);
    dif.M_dstE = F; dif.W_dstE = 7; dif.W_valE = 64'h77; dif.W_dstM = 2; dif.W_valM = 64'h44;
    tick(); chk("fwd_wm", dif.E_valA, 64'h44); chk("fwd_we", dif.E_valB, 64'h77);
    idle(); dif.D_icode = 4'hA; dif.D_rA = 5; #1;
    chk("push_d_srcB", dif.d_srcB, 4'h4);
    tick(); chk("push_dstE", dif.E_dstE, 4'h4); chk("push_srcA", dif.E_srcA, 4'h5);
    dif.D_icode = 4'hB; dif.D_rA = 5; tick();
    chk("pop_srcA", dif.E_srcA, 4'h4); chk("pop_srcB", dif.E_srcB, 4'h4);
    chk("pop_dstE", dif.E_dstE, 4'h4); chk("pop_dstM", dif.E_dstM, 4'h5);
    dif.D_icode = 8; dif.D_rA = F; dif.D_valP = 64'h1D; tick();
    chk("call_valA", dif.E_valA, 64'h1D); chk("call_dstE", dif.E_dstE, 4'h4);
    idle(); dif.W_dstE = 4; dif.W_dstM = 4; dif.W_valE = 64'h100; dif.W_valM = 64'h200; tick();
    idle(); opq(4, 4); tick(); chk("dual_wr", dif.E_valA, 64'h200);
    idle(); dif.E_bubble = 1; dif.D_icode = 3; dif.D_rB = 6; dif.D_valC = 64'h77;
    dif.W_dstE = 6; dif.W_valE = 64'h99; tick();
    chk("bub_icode", dif.E_icode, 4'h1); chk("bub_valC", dif.E_valC, 64'h0); chk("bub_dstE", dif.E_dstE, F);
    idle(); opq(6, 6); tick(); chk("bub_wr", dif.E_valA, 64'h99);
    idle(); dif.D_icode = 4'hE; dif.D_stat = 1; dif.D_rA = 1; dif.D_rB = 2; tick();
    chk("inv_stat", dif.E_stat, 4'h1); chk("inv_srcA", dif.E_srcA, F);
    chk("inv_dstE", dif.E_dstE, F);    chk("inv_valA", dif.E_valA, 64'h0);
    idle(); opq(3, 5); dif.W_dstE = 5; dif.W_valE = 64'hAB; rst = 1; tick(); rst = 0;
    chk("mrst_icode", dif.E_icode, 4'h1);
    idle(); opq(3, 5); tick();
    chk("mrst_rf3", dif.E_valA, 64'h0); chk("mrst_nowr", dif.E_valB, 64'h0);
    idle(); tick();
    $display("Result: errors=%0d of %0d checks", errs, total);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
# decode_stage

Decode/write-back stage of the Y86-64 pipeline and consumer of the fetch→decode pipe register (D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP, D_stat).
- Holds the 15-entry, 64-bit register file.
- Picks source and destination register IDs and reads operands.
- Forwards in-flight results from E, M and W.
- Writes W-stage results into the register file.
- Loads the E pipe register each cycle, or inserts a bubble under hazard-unit control.

## Interface
Parameters:
- RSP, default 4'h4: stack-pointer register ID.
- RNONE, default 4'hF: "no register" ID.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- D_icode, D_ifun, D_rA, D_rB  in  4 each  decode pipe register fields.
- D_valC, D_valP  in  64 each  constant and fall-through PC.
- D_stat  in  4  status: 8=AOK, 4=HLT, 2=ADR, 1=INS.
- E_bubble  in  1  load a nop into E instead of the decoded instruction.
- e_dstE, e_valE  in  4/64  execute-stage result (post-cmov).
- M_dstE, M_valE, M_dstM, m_valM  in  4/64/4/64  memory-stage results.
- W_dstE, W_valE, W_dstM, W_valM  in  4/64/4/64  write-back results; also register-file write ports.
- d_srcA, d_srcB  out  4 each  combinational source IDs, to the hazard unit.
- E_icode, E_ifun, E_stat  out  4 each  execute pipe register.
- E_valC, E_valA, E_valB  out  64 each  execute pipe register.
- E_dstE, E_dstM, E_srcA, E_srcB  out  4 each  execute pipe register.

## Operation
Register selection (combinational, from D_icode):
- srcA = D_rA for 2, 4, 6, A; RSP for 9, B; else RNONE.
- srcB = D_rB for 4, 5, 6; RSP for 8, 9, A, B; else RNONE.
- dstE = D_rB for 2, 3, 6; RSP for 8, 9, A, B; else RNONE. Cmov condition is resolved in execute, not here.
- dstM = D_rA for 5, B; else RNONE.

valA selection, first match wins:
1. icode 7 or 8 → D_valP.
2. srcA==RNONE → 0.
3. srcA==e_dstE → e_valE.
4. srcA==M_dstM → m_valM.
5. srcA==M_dstE → M_valE.
6. srcA==W_dstM → W_valM.
7. srcA==W_dstE → W_valE.
8. Otherwise rf[srcA].

valB uses the same chain without the valP rule.

Forwarding rules:
- A forwarding source whose dst is RNONE never matches.
- Invalid D_icode (C–F) decodes with all IDs RNONE and valA=valB=0. D_stat passes through unchanged.

Register file:
- On the rising edge, write W_valE to rf[W_dstE] if W_dstE≠RNONE, and W_valM to rf[W_dstM] if W_dstM≠RNONE.
- If W_dstE==W_dstM≠RNONE, W_valM wins (popq %rsp).
- Same-cycle read of a register being written returns the new value through W forwarding, never the stale rf contents.

E register update on the rising edge:
- rst=1 → bubble, and all 15 registers cleared to 0.
- else E_bubble=1 → bubble; register-file writes still occur.
- else load icode, ifun, stat, valC, valA, valB, dstE, dstM, srcA, srcB from decode.

Bubble value: E_icode=1, E_ifun=0, E_stat=8, E_valC=E_valA=E_valB=0, all four IDs=RNONE.

## Timing
- Decode logic is combinational from D_* and the forwarding inputs. E outputs appear 1 cycle after D_* is valid.
- Register-file write latency: 1 edge. A subsequent decode reads the stored value from rf.
- Reset values: E outputs hold the bubble value and rf is all zero after the first edge with rst=1.
- rst mid-operation discards the in-flight decode. rst has priority over E_bubble and over W writes: no write occurs on a reset edge.
- The block has no stall input. The hazard unit stalls by holding D upstream and asserting E_bubble.
- d_srcA/d_srcB are valid in the same cycle as D_*, so load-use detection can be done against E_dstM.

## Test plan
- Reset: pulse rst, then D_icode=1 → E_icode=1, E_stat=8, all IDs=F, every rf entry reads 0.
- Write then read: W_dstE=3, W_valE=0x55, then D=OPq rA=3 rB=3 with no hazards → E_valA=E_valB=0x55, E_dstE=3.
- Forwarding priority: srcA=2 with e_dstE=2 (0x11), M_dstE=2 (0x22), W_dstE=2 (0x33) → E_valA=0x11. Drop e_dstE → 0x22.
- pushq/popq/call: D_icode=A, rA=5 → srcB=4, dstE=4. D_icode=B, rA=5 → srcA=srcB=4, dstE=4, dstM=5. D_icode=8, D_valP=0x1D → E_valA=0x1D.
- Dual write conflict: W_dstE=W_dstM=4, W_valE=0x100, W_valM=0x200 → rf[4]=0x200.
- Bubble and invalid: E_bubble=1 while D carries irmovq → E is a nop and the W write still lands. D_icode=E, D_stat=1 → E_stat=1, IDs=F.
